// File: rtl/ysyx_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter, round-robin, one outstanding transaction.
// Latency: upstream handshake in N -> mem_req_valid in N+1; response forwarded combinationally.
// Backpressure: upstream ready only in IDLE for the winner; mem_req held stable until mem_req_ready.
// Optional macro ARB_TIMEOUT_EN: WAIT watchdog that returns an error response after TIMEOUT cycles.
module ysyx_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state;
    logic              last_lsu;   // 1 = LSU was granted last
    logic              owner_lsu;  // owner of the transaction in flight
    logic              ifu_win;
    logic              lsu_win;
    logic              timeout_hit;
    logic              rsp_fire;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    // Round-robin winner: a lone requester wins; on a tie the master not granted last wins
    always_comb begin
        ifu_win = ifu_req_valid && (!lsu_req_valid || last_lsu);
        lsu_win = lsu_req_valid && !ifu_win;
    end

    // Ready only in IDLE and never while reset is held
    assign ifu_req_ready = reset && (state == IDLE) && ifu_win;
    assign lsu_req_ready = reset && (state == IDLE) && lsu_win;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;

    // Watchdog: cleared on entry to WAIT, counts every WAIT cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == REQ && mem_req_ready) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == WAIT) && !mem_rsp_valid && (wait_cnt == CNT_W'(TIMEOUT));
`else
    // Without the watchdog WAIT only ends on a memory response; TIMEOUT has no effect
    assign timeout_hit = (TIMEOUT < 0);
`endif

    // Response path: pass the memory response straight through to the owner; writes return 0
    always_comb begin
        rsp_fire = (state == WAIT) && (mem_rsp_valid || timeout_hit);
        rsp_data = (mem_wen || !mem_rsp_valid) ? '0 : mem_rsp_data;
        rsp_err  = mem_rsp_valid ? mem_rsp_err : 1'b1;
    end

    assign ifu_rsp_valid = rsp_fire && !owner_lsu;
    assign lsu_rsp_valid = rsp_fire && owner_lsu;
    assign ifu_rsp_data  = rsp_data;
    assign lsu_rsp_data  = rsp_data;
    assign ifu_rsp_err   = rsp_err;
    assign lsu_rsp_err   = rsp_err;

    // Transaction FSM with registered memory request fields
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_lsu      <= 1'b1;
            owner_lsu     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ifu_win || lsu_win) begin
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
                        owner_lsu     <= lsu_win;
                        last_lsu      <= lsu_win;
                        mem_addr      <= lsu_win ? lsu_addr : ifu_addr;
                        mem_wen       <= lsu_win && lsu_wen;
                        mem_wdata     <= lsu_win ? lsu_wdata : '0;
                        mem_wmask     <= lsu_win ? lsu_wmask : '0;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (rsp_fire) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Bench for ysyx_mem_arbiter: directed requests, expected memory requests and responses
// are queued at issue time and checked by an independent monitor.
// Define ARB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=4.
module tb_ysyx_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic          clock;
    logic          reset;
    logic          ifu_req_valid, ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_rsp_valid, ifu_rsp_err;
    logic [DW-1:0] ifu_rsp_data;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic [3:0]    lsu_wmask;
    logic          lsu_rsp_valid, lsu_rsp_err;
    logic [DW-1:0] lsu_rsp_data;
    logic          mem_req_valid, mem_req_ready, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_rsp_valid, mem_rsp_err;
    logic [DW-1:0] mem_rsp_data;

    ysyx_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic          lsu;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [3:0]    wmask;
    } mreq_t;

    rsp_t  rsp_q[$];
    mreq_t mreq_q[$];

    int errors = 0;
    int checks = 0;

    // Memory model configuration
    int            ready_dly = 1;
    int            rsp_dly   = 2;
    logic [DW-1:0] cfg_data  = '0;
    logic          cfg_err   = 1'b0;
    bit            silent    = 1'b0;
    bit            stray     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_rsp(input logic lsu, input logic [DW-1:0] data, input logic err);
        rsp_t r;
        r.lsu = lsu; r.data = data; r.err = err;
        rsp_q.push_back(r);
    endtask

    task automatic push_mreq(input logic [AW-1:0] addr, input logic wen,
                             input logic [DW-1:0] wdata, input logic [3:0] wmask);
        mreq_t m;
        m.addr = addr; m.wen = wen; m.wdata = wdata; m.wmask = wmask;
        mreq_q.push_back(m);
    endtask

    // Memory responder: ready after ready_dly cycles, response rsp_dly cycles after ready
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (stray) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hBAD0BAD0;
                @(posedge clock); #1;
                mem_rsp_valid = 1'b0;
                stray = 1'b0;
            end else if (reset && mem_req_valid) begin
                repeat (ready_dly) begin @(posedge clock); #1; end
                mem_req_ready = 1'b1;
                @(posedge clock); #1;
                mem_req_ready = 1'b0;
                if (!silent) begin
                    repeat (rsp_dly - 1) begin @(posedge clock); #1; end
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = cfg_data;
                    mem_rsp_err   = cfg_err;
                    @(posedge clock); #1;
                    mem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: compare every upstream response and every new memory request against the queues
    initial begin
        logic prev_vld;
        rsp_t  r;
        mreq_t m;
        prev_vld = 1'b0;
        forever begin
            @(negedge clock);
            if (ifu_rsp_valid || lsu_rsp_valid) begin
                check("rsp_single_owner", {ifu_rsp_valid, lsu_rsp_valid} == 2'b11, 1'b0);
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: ifu_rsp_valid=%0b lsu_rsp_valid=%0b, none expected",
                             ifu_rsp_valid, lsu_rsp_valid);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_owner_lsu", lsu_rsp_valid, r.lsu);
                    check("rsp_data", r.lsu ? lsu_rsp_data : ifu_rsp_data, r.data);
                    check("rsp_err", r.lsu ? lsu_rsp_err : ifu_rsp_err, r.err);
                end
            end
            if (mem_req_valid && !prev_vld) begin
                if (mreq_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mreq_unexpected: mem_addr=0x%0h, none expected", mem_addr);
                end else begin
                    m = mreq_q.pop_front();
                    check("mem_addr", mem_addr, m.addr);
                    check("mem_wen", mem_wen, m.wen);
                    check("mem_wdata", mem_wdata, m.wdata);
                    check("mem_wmask", mem_wmask, m.wmask);
                end
            end
            prev_vld = mem_req_valid;
        end
    end

    // Raise the selected request valids and drop each one after its handshake
    task automatic drive(input bit di, input bit dl);
        bit pi, pl, gi, gl;
        int n;
        pi = di; pl = dl; n = 0;
        @(posedge clock); #1;
        if (di) ifu_req_valid = 1'b1;
        if (dl) lsu_req_valid = 1'b1;
        while ((pi || pl) && n < 60) begin
            @(negedge clock);
            gi = pi && ifu_req_ready;
            gl = pl && lsu_req_ready;
            @(posedge clock); #1;
            if (gi) begin pi = 1'b0; ifu_req_valid = 1'b0; end
            if (gl) begin pl = 1'b0; lsu_req_valid = 1'b0; end
            n++;
        end
        if (pi || pl) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: ifu_pending=%0b lsu_pending=%0b", pi, pl);
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || mreq_q.size() != 0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        checks++;
        if (rsp_q.size() != 0 || mreq_q.size() != 0) begin
            errors++;
            $display("FAIL drain: rsp left %0d mreq left %0d, required 0 and 0", rsp_q.size(), mreq_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] stall_addr;
        int n;
        reset = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        ifu_addr = 32'h80000000; lsu_addr = 32'h80000100;
        lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        #12;
        check("reset_ifu_ready", ifu_req_ready, 1'b0);
        check("reset_lsu_ready", lsu_req_ready, 1'b0);
        check("reset_mem_req_valid", mem_req_valid, 1'b0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wen", mem_wen, 1'b0);
        check("reset_mem_wmask", mem_wmask, 4'h0);
        check("reset_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // IFU fetch alone
        cfg_data = 32'h00000413;
        push_mreq(32'h80000000, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h00000413, 1'b0);
        ifu_addr = 32'h80000000;
        drive(1'b1, 1'b0);
        drain();

        // Simultaneous requests after reset: IFU, LSU, IFU, LSU
        do_reset();
        cfg_data = 32'hCAFE0001;
        push_mreq(32'h80000010, 1'b0, 32'h0, 4'h0);
        push_mreq(32'h80000200, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b0, 32'hCAFE0001, 1'b0);
        push_rsp(1'b1, 32'hCAFE0001, 1'b0);
        ifu_addr = 32'h80000010; lsu_addr = 32'h80000200;
        drive(1'b1, 1'b1);
        push_mreq(32'h80000014, 1'b0, 32'h0, 4'h0);
        push_mreq(32'h80000204, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b0, 32'hCAFE0001, 1'b0);
        push_rsp(1'b1, 32'hCAFE0001, 1'b0);
        ifu_addr = 32'h80000014; lsu_addr = 32'h80000204;
        drive(1'b1, 1'b1);
        drain();

        // LSU store: write data returns 0 and the IFU-forced fields do not apply
        cfg_data = 32'h12345678;
        lsu_addr = 32'h80001000; lsu_wen = 1'b1; lsu_wdata = 32'hDEADBEEF; lsu_wmask = 4'hF;
        push_mreq(32'h80001000, 1'b1, 32'hDEADBEEF, 4'hF);
        push_rsp(1'b1, 32'h0, 1'b0);
        drive(1'b0, 1'b1);
        drain();
        lsu_wen = 1'b0; lsu_wmask = 4'h0; lsu_wdata = '0;

        // Memory stall: request stays stable and both held requesters stay blocked
        ready_dly = 6;
        stall_addr = 32'h80002040;
        lsu_addr = stall_addr; lsu_wen = 1'b1; lsu_wdata = 32'h0A0B0C0D; lsu_wmask = 4'h3;
        push_mreq(stall_addr, 1'b1, 32'h0A0B0C0D, 4'h3);
        push_rsp(1'b1, 32'h0, 1'b0);
        push_mreq(32'h80000020, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h12345678, 1'b0);
        drive(1'b0, 1'b1);
        ifu_addr = 32'h80000020; ifu_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_mem_req_valid", mem_req_valid, 1'b1);
            check("stall_mem_addr", mem_addr, stall_addr);
            check("stall_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
        end
        ready_dly = 1;
        drive(1'b1, 1'b0);
        drain();
        lsu_wen = 1'b0; lsu_wmask = 4'h0; lsu_wdata = '0;

        // Reset during WAIT abandons the transaction; a stray response is not forwarded
        silent = 1'b1;
        ifu_addr = 32'h80003000;
        push_mreq(32'h80003000, 1'b0, 32'h0, 4'h0);
        drive(1'b1, 1'b0);
        n = 0;
        while (mem_req_valid && n < 20) begin @(negedge clock); n++; end
        check("wait_reached_mem_req_valid", mem_req_valid, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #1;
        check("midreset_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
        check("midreset_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        check("midreset_mem_addr", mem_addr, 32'h0);
        @(negedge clock);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        reset = 1'b1;
        silent = 1'b0;
        stray = 1'b1;
        repeat (4) @(negedge clock);
        check("stray_consumed", stray, 1'b0);
        cfg_data = 32'h00100073;
        ifu_addr = 32'h80003004;
        push_mreq(32'h80003004, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h00100073, 1'b0);
        drive(1'b1, 1'b0);
        drain();

`ifdef ARB_TIMEOUT_EN
        // Silent memory: watchdog returns an error with zero data, then service resumes
        silent = 1'b1;
        ifu_addr = 32'h80004000;
        push_mreq(32'h80004000, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b0);
        drain();
        silent = 1'b0;
        cfg_data = 32'h55AA55AA;
        lsu_addr = 32'h80004100;
        push_mreq(32'h80004100, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b1, 32'h55AA55AA, 1'b0);
        drive(1'b0, 1'b1);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog on the whole run
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/ysyx_mem_arbiter.md
Name: ysyx_mem_arbiter

Overview:
- Two-master, one-slave memory arbiter for the NPC core.
- Shares the single memory port between the IFU (read-only fetch) and the LSU (load/store).
- Sits between the core pipeline and the memory model/SRAM inside the non-SoC top.
- Round-robin arbitration, one outstanding transaction at a time, sequenced by a 3-state FSM.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wmask width is DATA_W/8
TIMEOUT, 255, max WAIT cycles before an error response (only with ARB_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted
ifu_addr  in  ADDR_W  fetch address
ifu_rsp_valid  out  1  IFU response, one-cycle pulse
ifu_rsp_data  out  DATA_W  fetched word
ifu_rsp_err  out  1  IFU access error
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted
lsu_addr  in  ADDR_W  load/store address
lsu_wen  in  1  1 = write, 0 = read
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  byte strobes
lsu_rsp_valid  out  1  LSU response, one-cycle pulse
lsu_rsp_data  out  DATA_W  load data (0 for writes)
lsu_rsp_err  out  1  LSU access error
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  registered address
mem_wen  out  1  registered write enable
mem_wdata  out  DATA_W  registered write data
mem_wmask  out  DATA_W/8  registered byte strobes
mem_rsp_valid  in  1  memory response valid
mem_rsp_data  in  DATA_W  memory read data
mem_rsp_err  in  1  memory error

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=LSU.
  - All registered mem_* outputs = 0.
  - No *_rsp_valid or *_req_ready asserted.
  - Reset mid-transaction abandons the transaction; no response is issued.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Choose a winner combinationally.
    - Only one master valid: that master wins.
    - Both valid: the master other than last_grant wins. After reset this means IFU first.
  - The winner's *_req_ready=1; the loser's ready=0.
  - On handshake, latch addr/wen/wdata/wmask into the mem_* registers.
    - An IFU request forces wen=0, wmask=0.
  - Record the owner, set last_grant=owner, go to REQ.
- REQ:
  - mem_req_valid=1; mem_* held stable.
  - Both upstream ready signals are 0.
  - On mem_req_ready=1, go to WAIT.
- WAIT:
  - mem_req_valid=0.
  - When mem_rsp_valid=1, drive the owner's rsp_valid=1 in the same cycle (combinational pass-through).
    - rsp_data = mem_rsp_data; for an LSU write, rsp_data is forced to 0.
    - rsp_err = mem_rsp_err.
    - Go to IDLE.
  - The non-owner's rsp_valid is never asserted.
- Latency:
  - Upstream handshake in cycle N → mem_req_valid in N+1.
  - Response forwarded in the same cycle it arrives.
  - Minimum per-transaction occupancy is 3 cycles (IDLE, REQ, WAIT).
- A mem_rsp_valid arriving in IDLE or REQ is ignored and not forwarded.
- Upstream *_req_valid held through the busy period is not accepted until IDLE.
- A new request is accepted no earlier than the cycle after a response.
- Requesters always accept responses; there is no rsp_ready.

Optional Feature:
Macro ARB_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no mem_rsp_valid, the owner gets rsp_valid=1, rsp_err=1, rsp_data=0, and the FSM goes to IDLE.
  - A late memory response arriving afterwards is ignored, per the IDLE rule.
- Undefined:
  - No counter is instantiated; WAIT lasts indefinitely until mem_rsp_valid.

Test Plan:
- Reset, then IFU only, addr=0x80000000. Memory: ready 1 cycle later, rsp 2 cycles later with 0x00000413 → mem_addr=0x80000000, mem_wen=0; ifu_rsp_valid pulse with data 0x00000413; lsu_rsp_valid stays 0.
- IFU and LSU valid in the same cycle after reset → IFU granted first, LSU granted on the next IDLE. Repeat simultaneous requests → grants alternate IFU, LSU, IFU, LSU.
- LSU store, addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF → mem_wen=1, mem_wmask=0xF, wdata matches; lsu_rsp_data=0 even when mem_rsp_data=0x12345678.
- mem_req_ready held low 5 cycles → mem_req_valid and mem_addr stable for all 5 cycles; both upstream ready signals stay 0.
- Assert reset during WAIT, then deassert and feed a stray mem_rsp_valid → no rsp_valid to either master; FSM is in IDLE and accepts a new IFU request.
- With ARB_TIMEOUT_EN and TIMEOUT=4, memory never responds → rsp_valid with err=1, data=0 after the 4th WAIT cycle; next request accepted.
